// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared constants and types for the FIFO read-side controller.
//   FIFO_SIZE : default data word width
//   RD_CNT_W  : width of the optional delivered-word counter
//   occ_t     : skid buffer occupancy encoding
package fifo_pkg;

    localparam int FIFO_SIZE = 4;
    localparam int RD_CNT_W  = 16;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid
// Two-entry skid buffer with its occupancy FSM. The head entry is a register,
// so dout is registered and holds steady whenever no pop happens.
// Ports:
//   clk   in          clock
//   rst   in          synchronous active-high reset (discards any push that cycle)
//   push  in          write din this cycle
//   pop   in          head consumed this cycle
//   din   in  SIZE    word to write
//   dout  out SIZE    head word
//   occ   out 2       occupancy (OCC_EMPTY / OCC_ONE / OCC_FULL)
//
// state     | meaning
// ----------+-----------------------------------------
// OCC_EMPTY | no word buffered, head not valid
// OCC_ONE   | head holds one word
// OCC_FULL  | head and tail both hold words, tail is next
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int SIZE = FIFO_SIZE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [SIZE-1:0] din,
    output logic [SIZE-1:0] dout,
    output logic [1:0]      occ
);

    occ_t            state_q;
    occ_t            state_d;
    logic [SIZE-1:0] head_q;
    logic [SIZE-1:0] tail_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OCC_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            OCC_EMPTY: if (push) state_d = OCC_ONE;
            OCC_ONE: begin
                if (push && !pop)      state_d = OCC_FULL;
                else if (pop && !push) state_d = OCC_EMPTY;
            end
            // push without pop is unreachable here; push with pop refills the tail
            OCC_FULL: if (pop && !push) state_d = OCC_ONE;
            default: state_d = OCC_EMPTY;
        endcase
    end

    always_comb begin
        occ = state_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            unique case (state_q)
                OCC_EMPTY: if (push) head_q <= din;
                OCC_ONE: begin
                    if (push && pop) head_q <= din;
                    else if (push)   tail_q <= din;
                end
                OCC_FULL: begin
                    if (pop) begin
                        head_q <= tail_q;
                        if (push) tail_q <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout = head_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl
// Read-side controller: pops a 1-cycle-latency FIFO read port and presents the
// words on a valid/ready stream through a 2-entry skid buffer, sustaining one
// word per cycle with no bubbles.
// Optional feature macro: FIFO_RD_CNT_EN adds the rd_count output (16-bit
// wrapping count of delivered words); undefined, the port and logic are absent.
// Ports:
//   clk      in          clock
//   rst      in          synchronous active-high reset
//   r_data   in  SIZE    FIFO read data, valid the cycle after r_en
//   r_empty  in          FIFO empty flag
//   r_en     out         FIFO pop strobe
//   o_data   out SIZE    head word
//   o_valid  out         o_data valid
//   o_ready  in          sink accepts
//   rd_count out 16      words delivered (FIFO_RD_CNT_EN only)
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int SIZE = FIFO_SIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SIZE-1:0]     r_data,
    input  logic                r_empty,
    output logic                r_en,
    output logic [SIZE-1:0]     o_data,
    output logic                o_valid,
    input  logic                o_ready
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [RD_CNT_W-1:0] rd_count
`endif
);

    logic       inflight_q;
    logic       rst_q;
    logic       pop;
    logic [1:0] occ;
    logic [2:0] credit_sum;

    fifo_rd_skid #(.SIZE(SIZE)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .push (inflight_q),
        .pop  (pop),
        .din  (r_data),
        .dout (o_data),
        .occ  (occ)
    );

    assign o_valid = (occ != OCC_EMPTY);
    assign pop     = o_valid & o_ready;

    // Occupancy next cycle once the in-flight word lands; a new pop is only
    // issued if that still leaves room for the word it will bring.
    assign credit_sum = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};

    // rst_q keeps r_en low for the first cycle out of reset as well.
    assign r_en = ~r_empty & ~rst & ~rst_q & (credit_sum < 3'd2);

    always_ff @(posedge clk) begin
        rst_q <= rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= r_en;
        end
    end

`ifdef FIFO_RD_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= '0;
        end else if (pop) begin
            rd_count <= rd_count + RD_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
module tb_fifo_rd_ctrl;
    import fifo_pkg::*;

    localparam int SIZE = FIFO_SIZE;

    logic            clk     = 1'b0;
    logic            rst     = 1'b1;
    logic [SIZE-1:0] r_data  = '0;
    logic            r_empty = 1'b1;
    logic            r_en;
    logic [SIZE-1:0] o_data;
    logic            o_valid;
    logic            o_ready = 1'b0;
`ifdef FIFO_RD_CNT_EN
    logic [RD_CNT_W-1:0] rd_count;
`endif

    always #5 clk = ~clk;

    fifo_rd_ctrl #(.SIZE(SIZE)) dut (
        .clk     (clk),
        .rst     (rst),
        .r_data  (r_data),
        .r_empty (r_empty),
        .r_en    (r_en),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_ready (o_ready)
`ifdef FIFO_RD_CNT_EN
        ,
        .rd_count(rd_count)
`endif
    );

    int checks = 0;
    int errors = 0;
    int rd_pulses = 0;
    logic [SIZE-1:0] fifo_q[$];
    logic [SIZE-1:0] exp_q[$];
    bit gap_mode  = 1'b0;
    bit gap_phase = 1'b0;

    // FIFO read-port model plus output scoreboard.
    always begin : monitor
        logic            fire;
        logic [SIZE-1:0] e;
        @(negedge clk);
        fire = (r_en === 1'b1);
        if (fire) begin
            rd_pulses++;
            if (r_empty !== 1'b0) begin
                errors++;
                $display("FAIL r_en_while_empty: r_en=1 with r_empty=%0b, required r_en=0", r_empty);
            end
        end
        if (o_valid === 1'b1 && o_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got o_data=%0h, required no transfer", o_data);
            end else begin
                e = exp_q.pop_front();
                if (o_data !== e) begin
                    errors++;
                    $display("FAIL word_order: got o_data=%0h, required %0h", o_data, e);
                end
            end
        end
        @(posedge clk);
        #1;
        if (fire) begin
            if (fifo_q.size() > 0) begin
                r_data = fifo_q.pop_front();
            end else begin
                errors++;
                $display("FAIL fifo_underflow: popped empty FIFO model, required no pop");
            end
        end
        gap_phase = ~gap_phase;
        r_empty = (fifo_q.size() == 0) || (gap_mode && gap_phase);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [SIZE-1:0] w, input bit expect_out);
        fifo_q.push_back(w);
        if (expect_out) exp_q.push_back(w);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d words pending after %0d cycles, required 0", name, exp_q.size(), budget);
        end
    endtask

    task automatic test_reset();
        tick();
        rst = 1'b1;
        o_ready = 1'b1;
        for (int i = 1; i <= 4; i++) load(SIZE'(i), 1'b1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (r_en !== 1'b0 || o_valid !== 1'b0 || o_data !== '0) begin
                errors++;
                $display("FAIL reset_state: r_en=%0b o_valid=%0b o_data=%0h, required 0 0 0", r_en, o_valid, o_data);
            end
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (r_en !== 1'b0) begin
            errors++;
            $display("FAIL ren_after_reset: r_en=%0b in first cycle after reset, required 0", r_en);
        end
`ifdef FIFO_RD_CNT_EN
        checks++;
        if (rd_count !== '0) begin
            errors++;
            $display("FAIL count_reset: rd_count=%0h, required 0", rd_count);
        end
`endif
    endtask

    task automatic test_stream();
        bit exp_ren;
        bit exp_v;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_ren = (k <= 4);
            exp_v   = (k >= 3) && (k <= 6);
            checks++;
            if (r_en !== exp_ren) begin
                errors++;
                $display("FAIL stream_ren: cycle %0d r_en=%0b, required %0b", k, r_en, exp_ren);
            end
            checks++;
            if (o_valid !== exp_v) begin
                errors++;
                $display("FAIL stream_valid: cycle %0d o_valid=%0b, required %0b", k, o_valid, exp_v);
            end else if (exp_v && o_data !== SIZE'(k - 2)) begin
                errors++;
                $display("FAIL stream_data: cycle %0d o_data=%0h, required %0h", k, o_data, k - 2);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stream_drain: %0d words left, required 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int start;
        tick();
        o_ready = 1'b0;
        for (int i = 1; i <= 5; i++) load(SIZE'(i), 1'b1);
        start = rd_pulses;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c >= 6) begin
                checks++;
                if (o_valid !== 1'b1 || o_data !== SIZE'(1)) begin
                    errors++;
                    $display("FAIL bp_hold: o_valid=%0b o_data=%0h, required 1 1", o_valid, o_data);
                end
            end
        end
        checks++;
        if (rd_pulses - start != 2) begin
            errors++;
            $display("FAIL bp_pulses: %0d r_en pulses, required 2", rd_pulses - start);
        end
        tick();
        o_ready = 1'b1;
        wait_drain("bp", 40);
    endtask

    task automatic test_empty_gaps();
        int start;
        tick();
        gap_mode = 1'b1;
        o_ready  = 1'b1;
        start = rd_pulses;
        for (int i = 9; i <= 14; i++) load(SIZE'(i), 1'b1);
        wait_drain("gaps", 60);
        checks++;
        if (rd_pulses - start != 6) begin
            errors++;
            $display("FAIL gaps_pulses: %0d r_en pulses, required 6", rd_pulses - start);
        end
        gap_mode = 1'b0;
    endtask

    task automatic test_reset_midflight();
        int n = 0;
        tick();
        rst = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        tick();
        rst = 1'b0;
        o_ready = 1'b1;
        load(SIZE'(7), 1'b0);
        while (r_en !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (r_en !== 1'b1) begin
            errors++;
            $display("FAIL mid_ren_timeout: r_en=%0b after %0d cycles, required 1", r_en, n);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (o_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_discard: o_valid=%0b o_data=%0h, required o_valid 0", o_valid, o_data);
            end
        end
        load(SIZE'(8), 1'b1);
        wait_drain("mid", 20);
    endtask

`ifdef FIFO_RD_CNT_EN
    task automatic test_counter();
        tick();
        rst = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (rd_count !== '0) begin
            errors++;
            $display("FAIL count_clear: rd_count=%0h, required 0", rd_count);
        end
        tick();
        rst = 1'b0;
        o_ready = 1'b1;
        for (int i = 0; i < 32'h10002; i++) load(SIZE'(i), 1'b1);
        wait_drain("count", 70000);
        checks++;
        if (rd_count !== 16'h0002) begin
            errors++;
            $display("FAIL count_wrap: rd_count=%0h, required 0002", rd_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_empty_gaps();
        test_reset_midflight();
`ifdef FIFO_RD_CNT_EN
        test_counter();
`endif
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
